// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED register-bank write path.
//   SEL_*        : CPU store target selects (low16 / mid8 / high8 / invalid)
//   sched_state_t: write scheduler states (IDLE, ST_HI = status high beat pending)
//   gnt_t        : identity of the requester granted most recently
package led_ctrl_pkg;

    localparam logic [1:0] SEL_LOW  = 2'b00;
    localparam logic [1:0] SEL_MID  = 2'b01;
    localparam logic [1:0] SEL_HIGH = 2'b10;
    localparam logic [1:0] SEL_BAD  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        ST_HI = 1'b1
    } sched_state_t;

    typedef enum logic {
        GNT_CPU    = 1'b0,
        GNT_STATUS = 1'b1
    } gnt_t;

endpackage

// File: rtl/led_cpu_fifo.sv
// Synchronous store buffer for CPU LED writes. Each entry is {sel[1:0], data}.
//   led_clk : clock (posedge)
//   ledrst  : synchronous active-high reset, empties the buffer
//   push    : write din at the tail (caller guarantees !full)
//   pop     : drop the head entry (caller guarantees !empty)
//   din     : entry to store
//   dout    : current head entry (valid while !empty)
//   full    : DEPTH entries held
//   empty   : no entries held
module led_cpu_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 18
) (
    input  logic         led_clk,
    input  logic         ledrst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Storage carries no reset; only occupied slots are ever read.
    always_ff @(posedge led_clk) begin
        if (!ledrst && push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge led_clk) begin
        if (ledrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        dout  = mem[rd_ptr];
        full  = (count == CW'(DEPTH));
        empty = (count == '0);
    end

endmodule

// File: rtl/led_write_sched.sv
// Arbitrates and sequences all writes into the 24-bit LED register bank.
// CPU MMIO stores are buffered and issued one beat each; status updates are
// split into a low beat then a high beat with no CPU beat in between.
// Round-robin between the two when both are pending in IDLE.
//   led_clk   : clock (posedge)          ledrst    : sync active-high reset
//   cpu_wr    : CPU store strobe         cpu_sel   : 00 low16 01 mid8 10 high8 11 invalid
//   cpu_wdata : CPU store data           cpu_full  : store buffer full
//   st_req    : status request (level)   st_data   : status word, sampled at grant
//   st_ack    : status word captured     led_write : beat valid
//   led_low/led_mid/led_high : beat target select
//   led_wdata : beat data (holds between beats)
//   busy      : buffer non-empty or high beat pending
//   ovf       : sticky, a CPU store was dropped on a full buffer
module led_write_sched
    import led_ctrl_pkg::*;
#(
    parameter int CPU_FIFO_DEPTH = 2,
    parameter int DATA_W         = 16,
    parameter int LED_W          = 24
) (
    input  logic              led_clk,
    input  logic              ledrst,
    input  logic              cpu_wr,
    input  logic [1:0]        cpu_sel,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_full,
    input  logic              st_req,
    input  logic [LED_W-1:0]  st_data,
    output logic              st_ack,
    output logic              led_write,
    output logic              led_low,
    output logic              led_mid,
    output logic              led_high,
    output logic [DATA_W-1:0] led_wdata,
    output logic              busy,
    output logic              ovf
);

    localparam int ENT_W = DATA_W + 2;
    localparam int HI_W  = LED_W - DATA_W;

    sched_state_t      state;
    gnt_t              last_gnt;
    logic [HI_W-1:0]   hold_hi;

    logic [ENT_W-1:0]  fifo_din;
    logic [ENT_W-1:0]  fifo_dout;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              cpu_store;
    logic              cpu_gnt;
    logic              st_gnt;
    logic [1:0]        head_sel;
    logic [DATA_W-1:0] head_data;

    led_cpu_fifo #(
        .DEPTH (CPU_FIFO_DEPTH),
        .W     (ENT_W)
    ) u_cpu_fifo (
        .led_clk (led_clk),
        .ledrst  (ledrst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        cpu_store = cpu_wr && (cpu_sel != SEL_BAD);
        fifo_push = cpu_store && !fifo_full;
        fifo_din  = {cpu_sel, cpu_wdata};
        head_sel  = fifo_dout[ENT_W-1 -: 2];
        head_data = fifo_dout[DATA_W-1:0];

        // CPU wins when it is alone, or when status had the previous grant.
        cpu_gnt = 1'b0;
        st_gnt  = 1'b0;
        if (state == IDLE) begin
            if (!fifo_empty && (!st_req || last_gnt == GNT_STATUS)) begin
                cpu_gnt = 1'b1;
            end else if (st_req) begin
                st_gnt = 1'b1;
            end
        end
        fifo_pop = cpu_gnt;

        cpu_full = fifo_full;
        busy     = !fifo_empty || (state != IDLE);
    end

    always_ff @(posedge led_clk) begin
        if (ledrst) begin
            state     <= IDLE;
            last_gnt  <= GNT_STATUS;
            hold_hi   <= '0;
            st_ack    <= 1'b0;
            led_write <= 1'b0;
            led_low   <= 1'b0;
            led_mid   <= 1'b0;
            led_high  <= 1'b0;
            led_wdata <= '0;
            ovf       <= 1'b0;
        end else begin
            led_write <= 1'b0;
            led_low   <= 1'b0;
            led_mid   <= 1'b0;
            led_high  <= 1'b0;
            st_ack    <= 1'b0;

            // Full is judged before any same-edge pop, so the drop is sticky-flagged.
            if (cpu_store && fifo_full) begin
                ovf <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cpu_gnt) begin
                        led_write <= (head_sel != SEL_BAD);
                        led_low   <= (head_sel == SEL_LOW);
                        led_mid   <= (head_sel == SEL_MID);
                        led_high  <= (head_sel == SEL_HIGH);
                        led_wdata <= head_data;
                        last_gnt  <= GNT_CPU;
                    end else if (st_gnt) begin
                        led_write <= 1'b1;
                        led_low   <= 1'b1;
                        led_wdata <= st_data[DATA_W-1:0];
                        hold_hi   <= st_data[LED_W-1:DATA_W];
                        st_ack    <= 1'b1;
                        last_gnt  <= GNT_STATUS;
                        state     <= ST_HI;
                    end
                end
                ST_HI: begin
                    led_write <= 1'b1;
                    led_high  <= 1'b1;
                    led_wdata <= DATA_W'(hold_hi);
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_write_sched.sv
module tb_led_write_sched;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        ledrst;
    logic        cpu_wr;
    logic [1:0]  cpu_sel;
    logic [15:0] cpu_wdata;
    logic        cpu_full;
    logic        st_req;
    logic [23:0] st_data;
    logic        st_ack;
    logic        led_write;
    logic        led_low;
    logic        led_mid;
    logic        led_high;
    logic [15:0] led_wdata;
    logic        busy;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    led_write_sched #(
        .CPU_FIFO_DEPTH (DEPTH),
        .DATA_W         (16),
        .LED_W          (24)
    ) dut (
        .led_clk   (clk),
        .ledrst    (ledrst),
        .cpu_wr    (cpu_wr),
        .cpu_sel   (cpu_sel),
        .cpu_wdata (cpu_wdata),
        .cpu_full  (cpu_full),
        .st_req    (st_req),
        .st_data   (st_data),
        .st_ack    (st_ack),
        .led_write (led_write),
        .led_low   (led_low),
        .led_mid   (led_mid),
        .led_high  (led_high),
        .led_wdata (led_wdata),
        .busy      (busy),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a queue of buffered stores, a pending high
    // byte for an in-flight status word, and who was served last.
    logic [17:0] m_q[$];
    logic [17:0] m_e;
    int          m_pre;
    bit          m_hi_pend = 1'b0;
    logic [7:0]  m_hi_byte = '0;
    bit          m_last_status = 1'b1;
    bit          m_write = 1'b0, m_low = 1'b0, m_mid = 1'b0, m_high = 1'b0, m_ack = 1'b0;
    bit          m_ovf = 1'b0, m_full = 1'b0, m_busy = 1'b0;
    logic [15:0] m_wdata = '0;

    always @(posedge clk) begin
        if (ledrst) begin
            m_q.delete();
            m_hi_pend     = 1'b0;
            m_last_status = 1'b1;
            m_write = 1'b0; m_low = 1'b0; m_mid = 1'b0; m_high = 1'b0; m_ack = 1'b0;
            m_wdata = '0;
            m_ovf   = 1'b0;
        end else begin
            m_pre = m_q.size();
            m_write = 1'b0; m_low = 1'b0; m_mid = 1'b0; m_high = 1'b0; m_ack = 1'b0;
            if (m_hi_pend) begin
                m_write   = 1'b1;
                m_high    = 1'b1;
                m_wdata   = {8'h00, m_hi_byte};
                m_hi_pend = 1'b0;
            end else if (m_pre > 0 && (!st_req || m_last_status)) begin
                m_e     = m_q.pop_front();
                m_write = 1'b1;
                case (m_e[17:16])
                    2'b00:   m_low  = 1'b1;
                    2'b01:   m_mid  = 1'b1;
                    default: m_high = 1'b1;
                endcase
                m_wdata       = m_e[15:0];
                m_last_status = 1'b0;
            end else if (st_req) begin
                m_write       = 1'b1;
                m_low         = 1'b1;
                m_wdata       = st_data[15:0];
                m_ack         = 1'b1;
                m_hi_byte     = st_data[23:16];
                m_hi_pend     = 1'b1;
                m_last_status = 1'b1;
            end
            if (cpu_wr && cpu_sel != 2'b11) begin
                if (m_pre == DEPTH) m_ovf = 1'b1;
                else m_q.push_back({cpu_sel, cpu_wdata});
            end
        end
        m_full = (m_q.size() == DEPTH);
        m_busy = (m_q.size() > 0) || m_hi_pend;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_led_write", 32'(led_write), 32'(m_write));
            chk("cyc_led_low",   32'(led_low),   32'(m_low));
            chk("cyc_led_mid",   32'(led_mid),   32'(m_mid));
            chk("cyc_led_high",  32'(led_high),  32'(m_high));
            chk("cyc_led_wdata", 32'(led_wdata), 32'(m_wdata));
            chk("cyc_st_ack",    32'(st_ack),    32'(m_ack));
            chk("cyc_cpu_full",  32'(cpu_full),  32'(m_full));
            chk("cyc_busy",      32'(busy),      32'(m_busy));
            chk("cyc_ovf",       32'(ovf),       32'(m_ovf));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        ledrst = 1'b0; cpu_wr = 1'b0; cpu_sel = 2'b00; cpu_wdata = '0;
        st_req = 1'b0; st_data = '0;
    endtask

    task automatic do_reset();
        quiet();
        ledrst = 1'b1;
        tick();
        ledrst = 1'b0;
    endtask

    initial begin
        quiet();
        ledrst = 1'b1;

        // 1: reset held two cycles
        tick();
        tick();
        cmp_en = 1'b1;
        chk("t1_led_write", 32'(led_write), 32'd0);
        chk("t1_st_ack",    32'(st_ack),    32'd0);
        chk("t1_cpu_full",  32'(cpu_full),  32'd0);
        chk("t1_busy",      32'(busy),      32'd0);
        chk("t1_ovf",       32'(ovf),       32'd0);
        chk("t1_led_wdata", 32'(led_wdata), 32'd0);
        ledrst = 1'b0;

        // 2: single CPU low16 store
        cpu_wr = 1'b1; cpu_sel = 2'b00; cpu_wdata = 16'hA5A5;
        tick();
        cpu_wr = 1'b0;
        chk("t2_no_beat_yet", 32'(led_write), 32'd0);
        chk("t2_busy",        32'(busy),      32'd1);
        tick();
        chk("t2_write", 32'(led_write), 32'd1);
        chk("t2_low",   32'(led_low),   32'd1);
        chk("t2_wdata", 32'(led_wdata), 32'h0000A5A5);
        chk("t2_busy_fell", 32'(busy),  32'd0);
        tick();
        chk("t2_one_beat", 32'(led_write), 32'd0);
        chk("t2_wdata_hold", 32'(led_wdata), 32'h0000A5A5);

        // 3: status update from IDLE
        st_req = 1'b1; st_data = 24'h123456;
        tick();
        st_req = 1'b0;
        chk("t3_low",   32'(led_low),   32'd1);
        chk("t3_wdata", 32'(led_wdata), 32'h00003456);
        chk("t3_ack",   32'(st_ack),    32'd1);
        tick();
        chk("t3_high",  32'(led_high),  32'd1);
        chk("t3_hdata", 32'(led_wdata), 32'h00000012);
        chk("t3_ack0",  32'(st_ack),    32'd0);
        tick();

        // 4: both pending after reset, CPU served first
        do_reset();
        cpu_wr = 1'b1; cpu_sel = 2'b01; cpu_wdata = 16'h0001;
        tick();
        cpu_wr = 1'b0; st_req = 1'b1; st_data = 24'hABCDEF;
        tick();
        chk("t4_mid",   32'(led_mid),   32'd1);
        chk("t4_mdata", 32'(led_wdata), 32'h00000001);
        tick();
        chk("t4_low",   32'(led_low),   32'd1);
        chk("t4_ldata", 32'(led_wdata), 32'h0000CDEF);
        st_req = 1'b0;
        tick();
        chk("t4_high",  32'(led_high),  32'd1);
        chk("t4_hdata", 32'(led_wdata), 32'h000000AB);
        tick();

        // 5: overflow while status is in flight
        do_reset();
        st_req = 1'b1; st_data = 24'h55AA33;
        cpu_wr = 1'b1; cpu_sel = 2'b00; cpu_wdata = 16'h1111;
        tick();
        cpu_wdata = 16'h2222;
        chk("t5_low",   32'(led_wdata), 32'h0000AA33);
        tick();
        cpu_wdata = 16'h3333;
        chk("t5_high",  32'(led_wdata), 32'h00000055);
        chk("t5_full",  32'(cpu_full),  32'd1);
        tick();
        cpu_wr = 1'b0; st_req = 1'b0;
        chk("t5_ovf",   32'(ovf),       32'd1);
        chk("t5_beat1", 32'(led_wdata), 32'h00001111);
        tick();
        chk("t5_beat2", 32'(led_wdata), 32'h00002222);
        tick();
        chk("t5_no_third", 32'(led_write), 32'd0);
        chk("t5_ovf_sticky", 32'(ovf),     32'd1);
        chk("t5_empty", 32'(busy),         32'd0);

        // 6: reset while the low beat is visible
        do_reset();
        st_req = 1'b1; st_data = 24'h777888;
        tick();
        chk("t6_low", 32'(led_low), 32'd1);
        ledrst = 1'b1; st_req = 1'b0;
        tick();
        ledrst = 1'b0;
        chk("t6_write0", 32'(led_write), 32'd0);
        chk("t6_ack0",   32'(st_ack),    32'd0);
        chk("t6_busy0",  32'(busy),      32'd0);
        tick();
        chk("t6_no_high", 32'(led_write), 32'd0);

        // Randomized traffic against the reference
        for (int i = 0; i < 4000; i++) begin
            ledrst    = ($urandom_range(0, 249) == 0);
            cpu_wr    = 1'($urandom_range(0, 1));
            cpu_sel   = 2'($urandom_range(0, 3));
            cpu_wdata = 16'($urandom);
            if ($urandom_range(0, 3) == 0) st_req = ~st_req;
            st_data   = 24'($urandom);
            tick();
        end

        quiet();
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
